incident_frame_tx: RTL

//  Downstream of the incident detector. Captures each 4-byte incident record
//  (b0..b3) strobed by incident_inform and queues it in a small record FIFO.

---
 rtl/incident_frame_tx.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/incident_frame_tx.sv
// Buffers 4-byte incident records in a small FIFO and serialises each as a
// 6-byte frame {HDR, b0..b3, checksum} on a byte-wide valid/ready stream.
module incident_frame_tx #(
  parameter int         DEPTH  = 4,
  parameter int         ADDR_W = 2,
  parameter logic [7:0] HDR    = 8'h55
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       incident_inform,
  input  logic [7:0] incident_b0,
  input  logic [7:0] incident_b1,
  input  logic [7:0] incident_b2,
  input  logic [7:0] incident_b3,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       fifo_full,
  output logic       busy,
  output logic [7:0] overflow_cnt
);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  localparam logic [ADDR_W:0] L_DEPTH = DEPTH[ADDR_W:0];

  logic [31:0]       r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_full;
  logic [7:0]        r_ovf;

  state_t            r_state;
  logic [2:0]        r_idx;
  logic [7:0]        r_sh_b0, r_sh_b1, r_sh_b2, r_sh_b3, r_sh_chk;
  logic [7:0]        r_tx_data;
  logic              r_tx_valid;

  logic              w_pop;
  logic              w_push;
  logic              w_accept;
  logic [ADDR_W:0]   w_count_nxt;
  logic [31:0]       w_head;
  logic [7:0]        w_chk;
  logic [7:0]        w_next_byte;

  // A full FIFO still accepts a record on the edge that frees a slot.
  assign w_pop    = (r_state == S_IDLE) && (r_count != '0);
  assign w_push   = incident_inform && ((r_count != L_DEPTH) || w_pop);
  assign w_accept = r_tx_valid && tx_ready;
  assign w_head   = r_mem[r_rd_ptr];
  assign w_chk    = w_head[7:0] + w_head[15:8] + w_head[23:16] + w_head[31:24];

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + 1'b1;
    else if (!w_push && w_pop) w_count_nxt = r_count - 1'b1;
  end

  always_comb begin
    w_next_byte = r_sh_chk;
    case (r_idx)
      3'd0:    w_next_byte = r_sh_b0;
      3'd1:    w_next_byte = r_sh_b1;
      3'd2:    w_next_byte = r_sh_b2;
      3'd3:    w_next_byte = r_sh_b3;
      default: w_next_byte = r_sh_chk;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {incident_b3, incident_b2, incident_b1, incident_b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_ovf    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == L_DEPTH);
      if (incident_inform && !w_push && (r_ovf != 8'hFF)) r_ovf <= r_ovf + 1'b1;
    end
  end

  // Shadow copy lets the FIFO keep filling while a frame is on the wire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_sh_b0    <= '0;
      r_sh_b1    <= '0;
      r_sh_b2    <= '0;
      r_sh_b3    <= '0;
      r_sh_chk   <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_sh_b0    <= w_head[7:0];
            r_sh_b1    <= w_head[15:8];
            r_sh_b2    <= w_head[23:16];
            r_sh_b3    <= w_head[31:24];
            r_sh_chk   <= w_chk;
            r_idx      <= '0;
            r_tx_data  <= HDR;
            r_tx_valid <= 1'b1;
            r_state    <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_accept) begin
            if (r_idx == 3'd5) begin
              r_tx_valid <= 1'b0;
              r_tx_data  <= '0;
              r_state    <= S_IDLE;
            end else begin
              r_idx     <= r_idx + 1'b1;
              r_tx_data <= w_next_byte;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_data      = r_tx_data;
  assign tx_valid     = r_tx_valid;
  assign fifo_full    = r_full;
  assign overflow_cnt = r_ovf;
  assign busy         = (r_state != S_IDLE) || (r_count != '0);

endmodule
